// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc: round-robin multi-sensor HC-SR04 ranger reporting cm over valid/ready
//   hw_clk, rst_n            clock, async active-low reset
//   enable                   run the trigger/measure sequence
//   echo[NUM_CH]             raw asynchronous echo inputs
//   trig[NUM_CH]             one-hot trigger outputs
//   dist_valid/dist_ready    result handshake
//   dist_data/dist_ch/dist_timeout  distance in cm, channel, no-echo/over-range flag
module ultrasonic_ranger_mc #(
  parameter int CLK_HZ     = 12000000,
  parameter int NUM_CH     = 2,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 25000,
  parameter int GAP_US     = 60000,
  parameter int DIST_W     = 9,
  parameter int CH_W       = 3
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trig,
  output logic              dist_valid,
  input  logic              dist_ready,
  output logic [DIST_W-1:0] dist_data,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_timeout
);
  localparam int MHZ        = CLK_HZ / 1000000;
  localparam int TRIG_CYC   = MHZ * TRIG_US;
  localparam int TO_CYC     = MHZ * TIMEOUT_US;
  localparam int GAP_CYC    = MHZ * GAP_US;
  localparam longint CPC_L  = longint'(CLK_HZ) * 58 / 1000000;
  localparam int CYC_PER_CM = int'(CPC_L);
  localparam int CNT_MAX    = (TO_CYC > GAP_CYC) ? ((TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC)
                                                 : ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC);
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int PSC_W      = $clog2(CYC_PER_CM + 1);
  localparam int CH_N       = 2 ** CH_W;
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_REP, S_GAP} state_t;
  state_t            r_state, w_nstate;
  logic [NUM_CH-1:0] r_s1, r_s2, r_prev, r_trig;
  logic [CNT_W-1:0]  r_cnt, w_ncnt;
  logic [PSC_W-1:0]  r_psc, w_npsc;
  logic [DIST_W-1:0] r_cm, w_ncm, r_data, w_ndata, w_cm_inc;
  logic [CH_W-1:0]   r_ch, w_nch;
  logic              r_valid, w_nvalid, r_to, w_nto;
  logic [CH_N-1:0]   w_s2p, w_prevp;
  logic              w_rise, w_fall, w_tick;
  // Pad the synchronised vectors to the full channel-index range so r_ch indexes them exactly
  assign w_s2p    = CH_N'(r_s2);
  assign w_prevp  = CH_N'(r_prev);
  assign w_rise   = w_s2p[r_ch] & ~w_prevp[r_ch];
  assign w_fall   = ~w_s2p[r_ch] & w_prevp[r_ch];
  assign w_tick   = r_psc == PSC_W'(CYC_PER_CM - 1);
  assign w_cm_inc = (w_tick && !(&r_cm)) ? r_cm + 1'b1 : r_cm;
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 1'b1;
    w_npsc   = r_psc;
    w_ncm    = r_cm;
    w_nch    = r_ch;
    w_nvalid = r_valid;
    w_ndata  = r_data;
    w_nto    = r_to;
    case (r_state)
      S_IDLE: begin
        w_ncnt   = '0;
        w_nstate = enable ? S_TRIG : S_IDLE;
      end
      S_TRIG: if (r_cnt == CNT_W'(TRIG_CYC - 1)) begin
        w_nstate = S_WAIT;
        w_ncnt   = '0;
      end
      // An echo already high on entry leaves r_prev set, so only a fresh edge counts
      S_WAIT: if (w_rise) begin
        w_nstate = S_MEAS;
        w_ncnt   = '0;
        w_npsc   = '0;
        w_ncm    = '0;
      end else if (r_cnt == CNT_W'(TO_CYC - 1)) begin
        w_nstate = S_REP;
        w_nvalid = 1'b1;
        w_ndata  = '0;
        w_nto    = 1'b1;
      end
      // The fall cycle is still counted so the result is floor(high_cycles / CYC_PER_CM)
      S_MEAS: begin
        w_npsc = w_tick ? '0 : r_psc + 1'b1;
        w_ncm  = w_cm_inc;
        if (w_fall) begin
          w_nstate = S_REP;
          w_nvalid = 1'b1;
          w_ndata  = w_cm_inc;
          w_nto    = 1'b0;
        end else if (r_cnt == CNT_W'(TO_CYC - 1)) begin
          w_nstate = S_REP;
          w_nvalid = 1'b1;
          w_ndata  = '1;
          w_nto    = 1'b1;
        end
      end
      S_REP: begin
        w_ncnt = '0;
        if (dist_ready) begin
          w_nstate = S_GAP;
          w_nvalid = 1'b0;
        end
      end
      S_GAP: if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
        w_ncnt   = '0;
        w_nch    = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
        w_nstate = enable ? S_TRIG : S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_trig  <= '0;
      r_cnt   <= '0;
      r_psc   <= '0;
      r_cm    <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_s1    <= echo;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_trig  <= (w_nstate == S_TRIG) ? NUM_CH'(1) << w_nch : '0;
      r_cnt   <= w_ncnt;
      r_psc   <= w_npsc;
      r_cm    <= w_ncm;
      r_ch    <= w_nch;
      r_valid <= w_nvalid;
      r_data  <= w_ndata;
      r_to    <= w_nto;
    end
  end
  assign trig         = r_trig;
  assign dist_valid   = r_valid;
  assign dist_data    = r_data;
  assign dist_ch      = r_ch;
  assign dist_timeout = r_to;
endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// tb_ultrasonic_ranger_mc: directed bench for ultrasonic_ranger_mc with a result-level reference model
module tb_ultrasonic_ranger_mc;
  localparam int NCH = 3, DW = 5, CW = 2;
  localparam int CPC = 58, TRIG_CYC = 10, TO_CYC = 2000, GAP_CYC = 300, DMAX = 31;
  logic hw_clk = 1'b0, rst_n = 1'b1, enable = 1'b0, dist_ready = 1'b1;
  logic [NCH-1:0] echo = '0, trig;
  logic dist_valid, dist_timeout;
  logic [DW-1:0] dist_data;
  logic [CW-1:0] dist_ch;
  int n_checks = 0, n_fail = 0, n_hs = 0, n_rises = 0, cyc = 0;
  int q_ch[$], q_to[$], q_data[$];
  int last_ch = 0, last_to = 0, last_data = 0;
  int plen[NCH], pgo[NCH], pseen[NCH], pcnt[NCH];
  bit hold[NCH];
  ultrasonic_ranger_mc #(
    .CLK_HZ(1000000), .NUM_CH(NCH), .TRIG_US(10), .TIMEOUT_US(2000),
    .GAP_US(300), .DIST_W(DW), .CH_W(CW)
  ) dut (
    .hw_clk(hw_clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
    .dist_valid(dist_valid), .dist_ready(dist_ready), .dist_data(dist_data),
    .dist_ch(dist_ch), .dist_timeout(dist_timeout)
  );
  always #5 hw_clk = ~hw_clk;
  function automatic void check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  // Reference model: a pulse of w echo-high cycles (0 = no edge) yields one result
  function automatic void model_push(input int ch, input int w);
    int d;
    d = w / CPC;
    q_ch.push_back(ch);
    q_to.push_back((w == 0 || w > TO_CYC) ? 1 : 0);
    q_data.push_back(w == 0 ? 0 : (w > TO_CYC ? DMAX : (d > DMAX ? DMAX : d)));
  endfunction
  // Echo generator: drives each channel high for a requested number of cycles
  always @(posedge hw_clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (pgo[c] != pseen[c]) begin
        pseen[c] = pgo[c];
        pcnt[c]  = plen[c];
      end
      echo[c] = (pcnt[c] > 0) || hold[c];
      if (pcnt[c] > 0) pcnt[c]--;
    end
  end
  logic [NCH-1:0] prev_trig = '0;
  logic [DW+CW:0] prev_out = '0;
  int rise_cyc = 0, fall_cyc = 0;
  bit have_fall = 0, prev_valid = 0, prev_hs = 0;
  always @(negedge hw_clk) begin
    cyc++;
    if (!rst_n) begin
      prev_trig  = '0;
      have_fall  = 0;
      prev_valid = 0;
      prev_hs    = 0;
    end else begin
      check($countones(trig) <= 1, "trig_onehot", int'(trig), 0);
      if (trig != 0 && prev_trig == 0) begin
        n_rises++;
        rise_cyc = cyc;
        if (have_fall) check(cyc - fall_cyc >= GAP_CYC, "trig_gap", cyc - fall_cyc, GAP_CYC);
      end
      if (trig == 0 && prev_trig != 0) begin
        fall_cyc  = cyc;
        have_fall = 1;
        check(cyc - rise_cyc == TRIG_CYC, "trig_width", cyc - rise_cyc, TRIG_CYC);
      end
      if (dist_valid) check(trig == 0, "trig_in_report", int'(trig), 0);
      if (prev_valid && !prev_hs && dist_valid)
        check({dist_timeout, dist_ch, dist_data} == prev_out, "report_stable",
              int'({dist_timeout, dist_ch, dist_data}), int'(prev_out));
      prev_hs = dist_valid && dist_ready;
      if (prev_hs) begin
        n_hs++;
        last_ch   = int'(dist_ch);
        last_to   = int'(dist_timeout);
        last_data = int'(dist_data);
        if (q_ch.size() == 0) check(0, "unexpected_result", last_ch, -1);
        else begin
          check(last_ch == q_ch[0], "model_ch", last_ch, q_ch[0]);
          check(last_to == q_to[0], "model_timeout", last_to, q_to[0]);
          check(last_data == q_data[0], "model_data", last_data, q_data[0]);
          void'(q_ch.pop_front());
          void'(q_to.pop_front());
          void'(q_data.pop_front());
        end
      end
      prev_valid = dist_valid;
      prev_out   = {dist_timeout, dist_ch, dist_data};
      prev_trig  = trig;
    end
  end
  task automatic check_zero(input string tag);
    check(trig == 0, {tag, "_trig"}, int'(trig), 0);
    check(dist_valid == 0, {tag, "_valid"}, int'(dist_valid), 0);
    check(dist_data == 0, {tag, "_data"}, int'(dist_data), 0);
    check(dist_ch == 0, {tag, "_ch"}, int'(dist_ch), 0);
    check(dist_timeout == 0, {tag, "_timeout"}, int'(dist_timeout), 0);
  endtask
  task automatic start(input int ch, input int w, input bit push);
    bit seen = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge hw_clk);
      if (trig != 0) begin
        seen = 1;
        break;
      end
    end
    check(seen && trig == (NCH'(1) << ch), "trig_channel", int'(trig), 1 << ch);
    if (!seen) return;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge hw_clk);
      if (trig == 0) begin
        seen = 1;
        break;
      end
    end
    check(seen, "trig_release", int'(trig), 0);
    repeat (50) @(posedge hw_clk);
    #1;
    plen[ch] = w;
    pgo[ch]++;
    if (push) model_push(ch, w);
  endtask
  task automatic finish(input int ch, input int to_l, input int data_l);
    int h0 = n_hs;
    bit seen = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge hw_clk);
      if (n_hs != h0) begin
        seen = 1;
        break;
      end
    end
    check(seen, "result_arrival", n_hs - h0, 1);
    if (seen) begin
      check(last_ch == ch, "lit_ch", last_ch, ch);
      check(last_to == to_l, "lit_timeout", last_to, to_l);
      check(last_data == data_l, "lit_data", last_data, data_l);
    end
  endtask
  task automatic ping(input int ch, input int w, input int to_l, input int data_l);
    start(ch, w, 1);
    finish(ch, to_l, data_l);
  endtask
  initial begin
    int nr, h0;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge hw_clk);
    check_zero("reset");
    @(posedge hw_clk);
    #1 rst_n = 1'b1;
    repeat (1000) @(negedge hw_clk);
    check_zero("idle");
    check(n_rises == 0, "idle_no_trig", n_rises, 0);
    @(posedge hw_clk);
    #1 enable = 1'b1;
    ping(0, 637, 0, 10);
    ping(1, 1160, 0, 20);
    ping(2, 1740, 0, 30);
    ping(0, 58, 0, 1);
    ping(1, 57, 0, 0);
    ping(2, 1900, 0, 31);
    ping(0, 0, 1, 0);
    ping(1, 2500, 1, 31);
    @(posedge hw_clk);
    #1 hold[2] = 1;
    ping(2, 0, 1, 0);
    @(posedge hw_clk);
    #1 hold[2] = 0;
    dist_ready = 1'b0;
    start(0, 637, 1);
    for (int k = 0; k < 3000; k++) begin
      @(negedge hw_clk);
      if (dist_valid) break;
    end
    check(dist_valid == 1, "bp_valid", int'(dist_valid), 1);
    nr = n_rises;
    repeat (1000) @(negedge hw_clk);
    check(dist_valid == 1, "bp_hold_valid", int'(dist_valid), 1);
    check(dist_data == 10, "bp_hold_data", int'(dist_data), 10);
    check(dist_ch == 0, "bp_hold_ch", int'(dist_ch), 0);
    check(n_rises == nr, "bp_no_trig", n_rises - nr, 0);
    h0 = n_hs;
    @(posedge hw_clk);
    #1 dist_ready = 1'b1;
    @(negedge hw_clk);
    @(negedge hw_clk);
    check(dist_valid == 0, "bp_drop", int'(dist_valid), 0);
    check(n_hs == h0 + 1, "bp_accept", n_hs - h0, 1);
    check(last_data == 10, "bp_data", last_data, 10);
    start(1, 1000, 0);
    repeat (300) @(negedge hw_clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (3) @(posedge hw_clk);
    #1 rst_n = 1'b1;
    ping(0, 637, 0, 10);
    start(1, 1160, 1);
    repeat (300) @(negedge hw_clk);
    @(posedge hw_clk);
    #1 enable = 1'b0;
    finish(1, 0, 20);
    nr = n_rises;
    repeat (800) @(negedge hw_clk);
    check(n_rises == nr, "parked_no_trig", n_rises - nr, 0);
    @(posedge hw_clk);
    #1 enable = 1'b1;
    ping(2, 1740, 0, 30);
    ping(0, 637, 0, 10);
    check(q_ch.size() == 0, "queue_drained", q_ch.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
